// File: rtl/sdram_burst_fifo_if.sv
// Handshake and status bundle between user logic (master) and sdram_burst_fifo (slave).
interface sdram_burst_fifo_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
);
  logic                  wr_req;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_req;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   use_num;
  logic                  burst_rdy;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_req, wr_data, rd_req,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           use_num, burst_rdy, overflow, underflow
  );

  modport slave (
    input  wr_req, wr_data, rd_req,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           use_num, burst_rdy, overflow, underflow
  );
endinterface

// File: rtl/sdram_burst_fifo.sv
// Single-clock FIFO for the SDRAM data paths: show-ahead or standard read,
// threshold/burst flags and sticky overflow/underflow, all registered.
module sdram_burst_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter bit FWFT       = 1'b1,
  parameter int BURST_LEN  = 8,
  parameter int AFULL_TH   = (1 << ADDR_WIDTH) - 4,
  parameter int AEMPTY_TH  = 4
) (
  input logic               i_clk,
  input logic               i_rst,
  input logic               i_clr,
  sdram_burst_fifo_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] LP_DEPTH  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [CW-1:0] LP_AFULL  = CW'(AFULL_TH);
  localparam logic [CW-1:0] LP_AEMPTY = CW'(AEMPTY_TH);
  localparam logic [CW-1:0] LP_BURST  = CW'(BURST_LEN);
  localparam logic [CW-1:0] LP_ONE    = CW'(1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [CW-1:0]         r_cnt;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_afull;
  logic                  r_aempty;
  logic                  r_burst;
  logic                  r_ovf;
  logic                  r_unf;
  logic                  r_rd_valid;
  logic [DATA_WIDTH-1:0] r_rd_data;

  logic                  w_flush;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [ADDR_WIDTH-1:0] w_rd_ptr_nxt;
  logic [CW-1:0]         w_cnt_nxt;
  logic [DATA_WIDTH-1:0] w_head_nxt;

  assign w_flush      = i_rst | i_clr;
  assign w_wr_acc     = bus.wr_req & ~r_full;
  assign w_rd_acc     = bus.rd_req & ~r_empty;
  assign w_rd_ptr_nxt = r_rd_ptr + ADDR_WIDTH'(w_rd_acc);

  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_cnt_nxt = r_cnt + LP_ONE;
      2'b01:   w_cnt_nxt = r_cnt - LP_ONE;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  // Next head word; bypass the write when it lands exactly at the new head slot
  // (write into empty, or simultaneous traffic at a fill level of one).
  always_comb begin
    w_head_nxt = r_mem[w_rd_ptr_nxt];
    if (w_wr_acc && (w_rd_ptr_nxt == r_wr_ptr))
      w_head_nxt = bus.wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_acc && !w_flush)
      r_mem[r_wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (w_flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_afull    <= 1'b0;
      r_aempty   <= 1'b1;
      r_burst    <= 1'b0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      if (w_wr_acc)
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      r_rd_ptr <= w_rd_ptr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_full   <= (w_cnt_nxt == LP_DEPTH);
      r_empty  <= (w_cnt_nxt == '0);
      r_afull  <= (w_cnt_nxt >= LP_AFULL);
      r_aempty <= (w_cnt_nxt <= LP_AEMPTY);
      r_burst  <= (w_cnt_nxt >= LP_BURST);
      if (bus.wr_req && r_full)
        r_ovf <= 1'b1;
      if (bus.rd_req && r_empty)
        r_unf <= 1'b1;
      if (FWFT) begin
        r_rd_valid <= (w_cnt_nxt != '0);
        r_rd_data  <= w_head_nxt;
      end else begin
        r_rd_valid <= w_rd_acc;
        if (w_rd_acc)
          r_rd_data <= r_mem[r_rd_ptr];
      end
    end
  end

  assign bus.rd_data      = r_rd_data;
  assign bus.rd_valid     = r_rd_valid;
  assign bus.full         = r_full;
  assign bus.empty        = r_empty;
  assign bus.almost_full  = r_afull;
  assign bus.almost_empty = r_aempty;
  assign bus.use_num      = r_cnt;
  assign bus.burst_rdy    = r_burst;
  assign bus.overflow     = r_ovf;
  assign bus.underflow    = r_unf;
endmodule
